// File: rtl/fetch_ctrl_if.sv
// Fetch-stage control bundle between fetch_ctrl and the IF/ID datapath.
// master: the sequencing controller; slave: the datapath consuming its controls.
interface fetch_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             IMEM_READY;
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_Rt;
    logic [4:0]       IF_ID_Rs;
    logic [4:0]       IF_ID_Rt;
    logic             EX_BranchTaken;
    logic [31:0]      EX_Target;
    logic             CNTEN;
    logic             PCsel;
    logic [31:0]      JumporBranch;
    logic             IFID_WEN;
    logic             IFID_FLUSH;
    logic             ID_BUBBLE;
    logic [1:0]       STATE;
    logic [CNT_W-1:0] STALL_CNT;
    logic [CNT_W-1:0] REDIR_CNT;

    modport master (
        input  IMEM_READY, ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt,
               EX_BranchTaken, EX_Target,
        output CNTEN, PCsel, JumporBranch, IFID_WEN, IFID_FLUSH, ID_BUBBLE,
               STATE, STALL_CNT, REDIR_CNT
    );

    modport slave (
        output IMEM_READY, ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt,
               EX_BranchTaken, EX_Target,
        input  CNTEN, PCsel, JumporBranch, IFID_WEN, IFID_FLUSH, ID_BUBBLE,
               STATE, STALL_CNT, REDIR_CNT
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: boot hold-off, imem wait, load-use stall and
// branch/jump redirect in one FSM, plus saturating stall/redirect counters.
module fetch_ctrl #(
    parameter int unsigned BOOT_CYCLES = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic          CLK,
    input  logic          RSTB,
    fetch_ctrl_if.master  bus
);

    localparam logic [7:0] BootLast = 8'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {
        StBoot     = 2'd0,
        StRun      = 2'd1,
        StWait     = 2'd2,
        StRedirect = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       boot_cnt_q, boot_cnt_d;
    logic [31:0]      target_q;
    logic             pcsel_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] redir_cnt_q;

    logic hz;
    logic capture;
    logic cnten;
    logic ifid_wen;
    logic ifid_flush;
    logic id_bubble;

    // Load-use hazard: load in EX writes a register the ID instruction reads.
    assign hz = bus.ID_EX_MemRead & (bus.ID_EX_Rt != 5'd0) &
                ((bus.ID_EX_Rt == bus.IF_ID_Rs) | (bus.ID_EX_Rt == bus.IF_ID_Rt));

    // Next-state and combinational fetch controls.
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        capture    = 1'b0;
        cnten      = 1'b0;
        ifid_wen   = 1'b1;
        ifid_flush = 1'b0;
        id_bubble  = 1'b0;
        case (state_q)
            StBoot: begin
                ifid_flush = 1'b1;
                id_bubble  = 1'b1;
                if (boot_cnt_q == BootLast) begin
                    state_d    = StRun;
                    boot_cnt_d = 8'd0;
                end else begin
                    boot_cnt_d = boot_cnt_q + 8'd1;
                end
            end
            StRun: begin
                if (bus.EX_BranchTaken) begin
                    capture    = 1'b1;
                    ifid_flush = 1'b1;
                    id_bubble  = 1'b1;
                    state_d    = StRedirect;
                end else if (!bus.IMEM_READY) begin
                    ifid_flush = 1'b1;
                    // ID instruction still advances; keep it out of EX on a load-use.
                    id_bubble  = hz;
                    state_d    = StWait;
                end else if (hz) begin
                    ifid_wen  = 1'b0;
                    id_bubble = 1'b1;
                end else begin
                    cnten = 1'b1;
                end
            end
            StWait: begin
                ifid_flush = 1'b1;
                id_bubble  = hz;
                if (bus.EX_BranchTaken) begin
                    capture = 1'b1;
                    state_d = StRedirect;
                end else if (bus.IMEM_READY) begin
                    // PC not advanced here; the fetch completes back in RUN.
                    state_d = StRun;
                end
            end
            StRedirect: begin
                cnten      = 1'b1;
                ifid_flush = 1'b1;
                id_bubble  = 1'b1;
                state_d    = StRun;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    // FSM state and boot hold-off counter.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q    <= StBoot;
            boot_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

    // Redirect target capture and registered PC mux select.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            target_q <= 32'h0000_0000;
            pcsel_q  <= 1'b0;
        end else begin
            if (capture) begin
                target_q <= bus.EX_Target;
            end
            pcsel_q <= (state_d == StRedirect);
        end
    end

    // Saturating performance counters.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if ((state_q != StBoot) && !cnten && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (capture && (redir_cnt_q != '1)) begin
                redir_cnt_q <= redir_cnt_q + 1'b1;
            end
        end
    end

    assign bus.CNTEN        = cnten;
    assign bus.PCsel        = pcsel_q;
    assign bus.JumporBranch = target_q;
    assign bus.IFID_WEN     = ifid_wen;
    assign bus.IFID_FLUSH   = ifid_flush;
    assign bus.ID_BUBBLE    = id_bubble;
    assign bus.STATE        = state_q;
    assign bus.STALL_CNT    = stall_cnt_q;
    assign bus.REDIR_CNT    = redir_cnt_q;

endmodule
